bit_memory_seq: RTL and testbench

Command-driven sequencer for a WIDTH-bit serial shift memory. A single-clock tick enable replaces the derived clock chain. The block accepts read and write commands over a valid/ready handshake and shifts one bit per tick. On a read it reassembles the shifted-out word. It sits between a command source (CPU register, test pattern generator) and the serial bit-storage path, and exposes the stored word in parallel for display and LEDs.

---
 rtl/bit_memory_seq_if.sv | 14 +
 rtl/bit_memory_seq.sv | 155 +++++++++++++++
 tb/tb_bit_memory_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_memory_seq_if.sv
// Command channel for bit_memory_seq: valid/ready handshake carrying a
// read/write flag and a WIDTH-bit write word.
interface bit_memory_seq_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_write;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;

  // Command source drives the request, sequencer answers with ready
  modport master (output cmd_valid, cmd_write, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_write, cmd_data, output cmd_ready);
endinterface

// File: rtl/bit_memory_seq.sv
// bit_memory_seq: command-driven sequencer for a WIDTH-bit serial shift
// memory. One bit moves per tick (every DIV clocks). Writes shift the
// command word in MSB first; reads shift the storage out and reassemble it
// into rd_data.
// Optional feature macro: BIT_MEMORY_SEQ_RECIRC_EN
//   defined   -> reads recirculate the outgoing bit (non-destructive read)
//   undefined -> reads shift in zeros (destructive read)
module bit_memory_seq #(
  parameter int WIDTH = 4,
  parameter int DIV   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_memory_seq_if.slave   cmd,
  output logic              busy,
  output logic              tick,
  output logic              ser_out,
  output logic [WIDTH-1:0]  mem,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  mem_q, mem_d;
  // Only the low WIDTH-1 capture bits ever reach rd_data; the top bit of a
  // full WIDTH-bit capture would be shifted out unused, so it is not kept.
  logic [WIDTH-2:0]  cap_q, cap_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic              wr_q, wr_d;

  logic              cmd_ready_w;
  logic              tick_w;
  logic              busy_w;
  logic              rd_valid_w;
  logic              accept;
  logic              last_tick;
  logic              read_bit;
  logic              in_bit;

  assign accept    = cmd.cmd_valid & cmd_ready_w;
  assign last_tick = tick_w & (bit_cnt_q == BIT_LAST);

`ifdef BIT_MEMORY_SEQ_RECIRC_EN
  // Recirculate: the bit leaving the top re-enters at the bottom
  assign read_bit = mem_q[WIDTH-1];
`else
  // Destructive read: storage fills with zeros as it is read out
  assign read_bit = 1'b0;
`endif

  // Writes take the next shadow bit (MSB first), reads take read_bit
  assign in_bit = wr_q ? shadow_q[WIDTH-1] : read_bit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last_tick) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output decode from registered state and counters (ready also gated by reset)
  always_comb begin
    cmd_ready_w = (state_q == IDLE) & rst_n;
    busy_w      = (state_q == SHIFT) | (state_q == DONE);
    tick_w      = (state_q == SHIFT) & (div_cnt_q == DIV_LAST);
    rd_valid_w  = (state_q == DONE) & ~wr_q;
  end

  // Datapath next values: command latch, tick divider, shift and capture
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    mem_d     = mem_q;
    cap_d     = cap_q;
    rd_data_d = rd_data_q;
    shadow_d  = shadow_q;
    wr_d      = wr_q;
    if (accept) begin
      wr_d      = cmd.cmd_write;
      shadow_d  = cmd.cmd_data;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      div_cnt_d = tick_w ? '0 : div_cnt_q + DW'(1);
      if (tick_w) begin
        mem_d     = {mem_q[WIDTH-2:0], in_bit};
        cap_d     = {cap_q[WIDTH-3:0], mem_q[WIDTH-1]};
        bit_cnt_d = bit_cnt_q + BW'(1);
        shadow_d  = shadow_q << 1;
        // The final captured bit lands directly in rd_data as DONE begins
        if (last_tick && !wr_q) begin
          rd_data_d = {cap_q, mem_q[WIDTH-1]};
        end
      end
    end
  end

  // Datapath registers; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      mem_q     <= '0;
      cap_q     <= '0;
      rd_data_q <= '0;
      shadow_q  <= '0;
      wr_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      mem_q     <= mem_d;
      cap_q     <= cap_d;
      rd_data_q <= rd_data_d;
      shadow_q  <= shadow_d;
      wr_q      <= wr_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_w;
  assign busy          = busy_w;
  assign tick          = tick_w;
  assign rd_valid      = rd_valid_w;
  assign ser_out       = mem_q[WIDTH-1];
  assign mem           = mem_q;
  assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_bit_memory_seq.sv
// Self-checking bench for bit_memory_seq (WIDTH=4, DIV=2): table of
// commands plus hand-written sequences; read results go through a queue.
module tb_bit_memory_seq;

  localparam int W = 4;
  localparam int D = 2;

`ifdef BIT_MEMORY_SEQ_RECIRC_EN
  localparam bit RECIRC = 1'b1;
`else
  localparam bit RECIRC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_memory_seq_if #(.WIDTH(W)) cmd_if ();

  logic         busy, tick, ser_out, rd_valid;
  logic [W-1:0] mem, rd_data;

  bit_memory_seq #(.WIDTH(W), .DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd_if.slave),
    .busy     (busy),
    .tick     (tick),
    .ser_out  (ser_out),
    .mem      (mem),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] sb_exp;
  logic [W-1:0] model_mem;

  typedef struct {
    logic         wr;
    logic [W-1:0] data;
    logic [W-1:0] exp_rd;
    logic [W-1:0] exp_mem;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Read-result scoreboard: every rd_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_valid_unexpected", {31'b0, rd_valid}, 32'd0);
      end else begin
        sb_exp = sb.pop_front();
        check("rd_data", rd_data, sb_exp);
        $display("read complete rd_data=%b expected=%b", rd_data, sb_exp);
      end
    end
  end

  task automatic apply_reset(input int cycles);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = 1'b1;
    cmd_if.cmd_data  = '1;
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", cmd_if.cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_tick", tick, 0);
      check("rst_mem", mem, 0);
      check("rst_rd", {rd_valid, rd_data}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("rel_ready", cmd_if.cmd_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_mem", mem, 0);
    model_mem = '0;
    $display("reset applied for %0d cycles", cycles);
  endtask

  // Issue one command and follow it to completion; ser_out seen on ticks
  // must replay the prior storage contents MSB first.
  task automatic do_cmd(input logic wr, input logic [W-1:0] data, input logic [W-1:0] exp_rd);
    int n;
    int tcnt;
    int rcnt;
    logic [W-1:0] ser_w;
    logic [W-1:0] prior;
    n = 0;
    while (!cmd_if.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", cmd_if.cmd_ready, 1);
    prior = model_mem;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = wr;
    cmd_if.cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = ~data;
    if (!wr) sb.push_back(exp_rd);
    tcnt = 0;
    rcnt = 0;
    ser_w = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tick) begin
        ser_w = {ser_w[W-2:0], ser_out};
        tcnt++;
      end
      if (rd_valid) rcnt++;
      if (!busy) break;
    end
    check("cmd_done_timeout", busy, 0);
    check("cmd_ticks", tcnt, W);
    check("cmd_rd_pulses", rcnt, wr ? 0 : 1);
    check("cmd_ser_seq", ser_w, prior);
    model_mem = wr ? data : (RECIRC ? prior : '0);
    $display("cmd wr=%0b data=%b mem=%b ser=%b ticks=%0d", wr, data, mem, ser_w, tcnt);
  endtask

  initial begin
    int n;
    int tcnt;
    logic [W-1:0] exp_m;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_write = 1'b0;
    cmd_if.cmd_data  = '0;
    model_mem = '0;

    vecs[0] = '{1'b1, 4'b0110, 4'b0000, 4'b0110};
    vecs[1] = '{1'b0, 4'b0000, 4'b0110, RECIRC ? 4'b0110 : 4'b0000};
    vecs[2] = '{1'b1, 4'b1001, 4'b0000, 4'b1001};
    vecs[3] = '{1'b0, 4'b0000, 4'b1001, RECIRC ? 4'b1001 : 4'b0000};
    vecs[4] = '{1'b0, 4'b0000, RECIRC ? 4'b1001 : 4'b0000, RECIRC ? 4'b1001 : 4'b0000};
    vecs[5] = '{1'b1, 4'b1111, 4'b0000, 4'b1111};
    vecs[6] = '{1'b1, 4'b0001, 4'b0000, 4'b0001};
    vecs[7] = '{1'b0, 4'b0000, 4'b0001, RECIRC ? 4'b0001 : 4'b0000};

    // Reset held 3 cycles with a pending command that must not be accepted
    apply_reset(3);

    // Write 1011 with cycle-exact mem/tick/busy/ready checks
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = 1'b1;
    cmd_if.cmd_data  = 4'b1011;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = 4'b0000;
    tcnt = 0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      exp_m = 4'b1011 >> (W - ((k / 2 > W) ? W : k / 2));
      check("wr_mem", mem, exp_m);
      check("wr_ser", ser_out, exp_m[W-1]);
      check("wr_tick", tick, ((k % 2 == 1) && k <= 7) ? 1 : 0);
      check("wr_busy", busy, (k <= 8) ? 1 : 0);
      check("wr_ready", cmd_if.cmd_ready, (k == 9) ? 1 : 0);
      check("wr_rd_valid", rd_valid, 0);
      if (tick) tcnt++;
      $display("write step N+%0d mem=%b tick=%0b busy=%0b", k, mem, tick, busy);
    end
    check("wr_tick_count", tcnt, W);
    model_mem = 4'b1011;

    // Read back 1011: ser sequence 1,0,1,1 and rd_data through the scoreboard
    do_cmd(1'b0, 4'b0000, 4'b1011);
    check("rd_mem_after", mem, RECIRC ? 4'b1011 : 4'b0000);
    check("rd_data_held", rd_data, 4'b1011);

    // Table-driven command list
    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].wr, vecs[i].data, vecs[i].exp_rd);
      check("vec_mem", mem, vecs[i].exp_mem);
    end

    // cmd_valid held high, data changes mid-command; back-to-back read
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = 1'b1;
    cmd_if.cmd_data  = 4'b1100;
    @(posedge clk);
    #1;
    cmd_if.cmd_write = 1'b0;
    cmd_if.cmd_data  = 4'b0011;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) check("hold_mem", mem, 4'b1100);
      if (k == 9) begin
        check("hold_ready", cmd_if.cmd_ready, 1);
        check("hold_busy", busy, 0);
        sb.push_back(4'b1100);
      end
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_accept", busy, 1);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_timeout", busy, 0);
    check("b2b_mem", mem, RECIRC ? 4'b1100 : 4'b0000);
    $display("back-to-back read done mem=%b rd_data=%b", mem, rd_data);

    // Reset mid-read after 2 ticks: abort, no rd_valid, rd_data stays 0
    apply_reset(1);
    do_cmd(1'b1, 4'b1011, 4'b0000);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = 1'b0;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    tcnt = 0;
    n = 0;
    while (tcnt < 2 && n < 20) begin
      @(negedge clk);
      if (tick) tcnt++;
      n++;
    end
    check("abort_ticks", tcnt, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_mem", mem, 0);
    check("abort_rd_data", rd_data, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", cmd_if.cmd_ready, 1);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_valid) n++;
    end
    check("abort_no_rd_valid", n, 0);
    $display("reset mid-read mem=%b rd_data=%b", mem, rd_data);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
